// File: rtl/axis_fifo_if.sv
// AXI4-Stream beat bundle: payload, sideband and the valid/ready handshake.
// The master modport drives the beat; the slave modport returns tready.
interface axis_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 16
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [STRB_WIDTH-1:0] tstrb;
  logic [STRB_WIDTH-1:0] tkeep;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata, tstrb, tkeep, tid, tdest, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tid, tdest, tuser, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI4-Stream FIFO carrying the full sideband per beat.
// Reports stored beats (level) and stored beats with tlast set (packets).
module axis_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 16,
  parameter int DEPTH      = 16,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  axis_fifo_if.slave    s,
  axis_fifo_if.master   m,
  output logic [CW-1:0] level,
  output logic [CW-1:0] packets
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = DATA_WIDTH + 2 * KW + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rdy_en;
  logic          push;
  logic          pop;
  logic          pkt_in;
  logic          pkt_out;

  // Full and empty come from level alone; the pointers are equal in both cases.
  assign s.tready = rdy_en && (level != FULL);
  assign m.tvalid = (level != '0);

  assign push    = s.tvalid && s.tready;
  assign pop     = m.tvalid && m.tready;
  assign pkt_in  = push && s.tlast;
  assign pkt_out = pop && m.tlast;

  assign {m.tdata, m.tstrb, m.tkeep, m.tid, m.tdest, m.tuser, m.tlast} = mem[rd_ptr];

  // NOTE: storage has no reset; contents are only visible behind m.tvalid, and
  // leaving it out keeps the array mappable onto plain RAM/flop arrays.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {s.tdata, s.tstrb, s.tkeep, s.tid, s.tdest, s.tuser, s.tlast};
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      packets <= '0;
    end else begin
      // Holds s.tready low for the first edge after reset release.
      rdy_en <= 1'b1;

      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;

      unique case ({push, pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase

      unique case ({pkt_in, pkt_out})
        2'b10:   packets <= packets + ONE;
        2'b01:   packets <= packets - ONE;
        default: packets <= packets;
      endcase
    end
  end
endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
- Synchronous first-word-fall-through FIFO for AXI4-Stream, with one slave (input) stream and one master (output) stream.
- Carries the full sideband per beat: tdata, tstrb, tkeep, tid, tdest, tuser and tlast.
- Sits directly upstream of any AXI4-Stream consumer in the core (e.g. bus/peripheral stream sinks) and decouples producer stalls from consumer stalls.
- Also reports occupancy and the number of complete packets buffered.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; must be a multiple of 8.
- ID_WIDTH, 4, tid width.
- DEST_WIDTH, 4, tdest width.
- USER_WIDTH, 16, tuser width.
- DEPTH, 16, number of beats stored; power of two, at least 2.
- Derived: STRB_WIDTH = KEEP_WIDTH = DATA_WIDTH/8; CW = $clog2(DEPTH)+1.

Ports:
- aclk  input  1  clock; all state changes on the rising edge.
- aresetn  input  1  asynchronous active-low reset.
- s_tdata/s_tstrb/s_tkeep/s_tid/s_tdest/s_tuser  input  per parameters  slave payload.
- s_tlast  input  1  slave end of packet.
- s_tvalid  input  1  slave beat valid.
- s_tready  output  1  FIFO can accept a beat.
- m_tdata/m_tstrb/m_tkeep/m_tid/m_tdest/m_tuser  output  per parameters  master payload.
- m_tlast  output  1  master end of packet.
- m_tvalid  output  1  master beat valid.
- m_tready  input  1  downstream accepts.
- level  output  CW  beats stored, range 0..DEPTH.
- packets  output  CW  stored beats with tlast=1.

Behaviour:
- Clock and reset: single clock domain, aclk only. aresetn is asynchronous and active-low, asserted asynchronously and released synchronously by the upstream reset logic.
- Reset values:
  - rd_ptr, wr_ptr, level, packets = 0.
  - m_tvalid = 0, s_tready = 0.
  - Payload storage is not reset; m_* payload is don't-care while m_tvalid=0.
- Ready-enable flop: rdy_en resets to 0 and is set to 1 on the first aclk edge after aresetn deasserts. s_tready = rdy_en && (level != DEPTH). s_tready is therefore low during reset and for the first post-reset edge.
- Push and pop:
  - push = s_tvalid && s_tready.
  - pop = m_tvalid && m_tready.
  - Both follow AXI rules: a transfer occurs only on an edge where valid && ready are both high.
- Push: write the payload at mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by level only, never by pointer equality.
- Level update: level += push - pop (the same edge covers simultaneous push and pop, so level is unchanged).
- Packet count: packets += (push && s_tlast) - (pop && m_tlast). Both may occur on one edge. Invariant: packets <= level.
- Master outputs: m_tvalid = (level != 0); m_* payload = mem[rd_ptr] (fall-through, combinational read of registered storage).
- Latency: a beat accepted on edge N is presented with m_tvalid=1 after edge N, one cycle latency when empty. It can be popped on edge N+1 at the earliest. There is no combinational path from s_* to m_*.
- Full (level==DEPTH):
  - s_tready=0 and no push occurs.
  - A pop on that edge drops level to DEPTH-1, so s_tready returns high the next cycle.
  - No push/pop bypass at full.
- Empty (level==0):
  - m_tvalid=0, so no pop.
  - A push on that edge makes m_tvalid high the next cycle.
- Stability: once m_tvalid=1, m_tvalid and the m_* payload hold until a pop. This follows from the FIFO structure and must hold under all stimulus.
- Ordering: beats emerge in acceptance order with every sideband field bit-exact. No beats are dropped or duplicated.
- Reset mid-operation: asserting aresetn clears all contents immediately (asynchronously), forcing m_tvalid=0, s_tready=0, level=0 and packets=0. Any partially transferred packet is discarded.
- Inputs with s_tvalid=0 are ignored regardless of payload; X on the payload while s_tvalid=0 must not propagate.

Test Plan:
- Reset: hold aresetn=0 for 3 cycles with s_tvalid=1, then release.
  - During reset: s_tready=0, m_tvalid=0, level=0.
  - s_tready=1 from the second edge after release.
  - The first accepted beat appears on m_* one cycle later.
- Fill/drain: DEPTH=16, m_tready=0, push beats tdata=0..15 with tlast on beats 3 and 15.
  - After 16 pushes: s_tready=0, level=16, packets=2; a 17th s_tvalid is not accepted.
  - Then m_tready=1: 0..15 are output in order, tlast on beats 3 and 15, packets decrements 2→1→0.
- Simultaneous push/pop at level=5: hold both handshakes high for 10 cycles with 2 tlast beats in and 1 out.
  - level stays 5; packets net +1.
- Full boundary: at level=16, assert m_tready for one cycle.
  - level=15, s_tready=1 the next cycle.
  - A push then returns level to 16 with no beat loss (checked by a scoreboard).
- Wrap-around: randomized s_tvalid/m_tready at 50% each for 1000 beats with random tid/tdest/tuser/tkeep/tstrb.
  - Scoreboard matches every field.
  - m_* stays stable while m_tvalid && !m_tready.
  - level never exceeds 16.
- Async reset mid-packet: at level=7, packets=1, assert aresetn between clock edges.
  - m_tvalid, level and packets go to 0 immediately, before the next edge.
  - After release, the FIFO is empty and outputs the new data only.
